serial_adder_ctrl: RTL and testbench

- Sequencer that drives one shared 1-bit add datapath (two half-adder stages forming a full adder) once per clock, building a WIDTH-bit sum LSB-first.
- Trades area for latency: one bit slice is reused for WIDTH cycles instead of instantiating WIDTH full adders.
- Sits between an operand producer and a result consumer, using a start/busy/done handshake.

---
 rtl/serial_adder_ctrl_if.sv | 36 +++
 rtl/serial_adder_ctrl.sv | 117 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// Start/busy/done handshake and operand/result bus for serial_adder_ctrl.
// Port sub exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] SUM;
    logic             COUT;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (
        output start, A, B, sub,
        input  busy, done, SUM, COUT
    );
    modport slave (
        input  start, A, B, sub,
        output busy, done, SUM, COUT
    );
`else
    modport master (
        output start, A, B,
        input  busy, done, SUM, COUT
    );
    modport slave (
        input  start, A, B,
        output busy, done, SUM, COUT
    );
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice reused WIDTH cycles, LSB first.
// Define SERIAL_ADDER_SUB_EN to add a sub input (A-B via ~B and carry-in 1).
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_adder_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             load;
    logic             shift;
    logic             last;

    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             cout_q;

    logic             s1;
    logic             c1;
    logic             s;
    logic             c2;
    logic             carry_d;

    // Two cascaded half adders form the shared full-adder slice
    assign s1      = sh_a[0] ^ sh_b[0];
    assign c1      = sh_a[0] & sh_b[0];
    assign s       = s1 ^ carry;
    assign c2      = s1 & carry;
    assign carry_d = c1 | c2;

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                shift = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a   <= '0;
            sh_b   <= '0;
            sum_q  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
        end else if (load) begin
            sh_a <= bus.A;
            cnt  <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            sh_b  <= bus.sub ? ~bus.B : bus.B;
            carry <= bus.sub;
`else
            sh_b  <= bus.B;
            carry <= 1'b0;
`endif
        end else if (shift) begin
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            sum_q <= {s, sum_q[WIDTH-1:1]};
            carry <= carry_d;
            cnt   <= cnt + 1'b1;
            if (last) begin
                cout_q <= carry_d;
            end
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.SUM  = sum_q;
    assign bus.COUT = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases plus random
// operands compared against plain integer arithmetic.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected result from ordinary integer arithmetic
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sb, output logic [W-1:0] es,
                         output logic ec);
        logic [W:0] t;
        if (sb) begin
            es = a - b;
            ec = (a >= b);
        end else begin
            t  = {1'b0, a} + {1'b0, b};
            es = t[W-1:0];
            ec = t[W];
        end
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sb);
        bus.A = a;
        bus.B = b;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = sb;
`endif
    endtask

    // One complete operation from IDLE; inj>0 pulses a stray start
    // with A=AA during that busy cycle.
    task automatic run_op(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic sb,
                          input int inj);
        logic [W-1:0] es;
        logic         ec;
        int           lat;
        int           nbusy;
        int           ndone;
        model(a, b, sb, es, ec);
        bus.start = 1'b1;
        drive(a, b, sb);
        tick();
        bus.start = 1'b0;
        drive(W'($urandom), W'($urandom), 1'($urandom));
        lat   = 1;
        nbusy = 0;
        while (!bus.done && lat < 3 * W) begin
            if (bus.busy) nbusy++;
            if (inj > 0 && nbusy == inj) begin
                bus.start = 1'b1;
                bus.A     = W'(8'hAA);
            end else begin
                bus.start = 1'b0;
            end
            tick();
            lat++;
        end
        bus.start = 1'b0;
        chk({tag, "_lat"}, lat, W + 1);
        chk({tag, "_nbusy"}, nbusy, W);
        chk({tag, "_busy_at_done"}, int'(bus.busy), 0);
        chk({tag, "_sum"}, int'(bus.SUM), int'(es));
        chk({tag, "_cout"}, int'(bus.COUT), int'(ec));
        ndone = 0;
        tick();
        if (bus.done) ndone++;
        chk({tag, "_extra_done"}, ndone, 0);
        chk({tag, "_sum_hold"}, int'(bus.SUM), int'(es));
        chk({tag, "_cout_hold"}, int'(bus.COUT), int'(ec));
    endtask

    task automatic back_to_back();
        int lat;
        int nbusy;
        bus.start = 1'b1;
        drive(W'(8'h01), W'(8'h02), 1'b0);
        tick();
        drive(W'(8'h80), W'(8'h80), 1'b0);
        lat = 1;
        while (!bus.done && lat < 3 * W) begin
            tick();
            lat++;
        end
        chk("b2b_lat1", lat, W + 1);
        chk("b2b_sum1", int'(bus.SUM), 'h03);
        chk("b2b_cout1", int'(bus.COUT), 0);
        tick();
        lat   = 1;
        nbusy = 0;
        while (!bus.done && lat < 3 * W) begin
            if (bus.busy) nbusy++;
            tick();
            lat++;
        end
        bus.start = 1'b0;
        chk("b2b_lat2", lat, W + 1);
        chk("b2b_nbusy2", nbusy, W);
        chk("b2b_sum2", int'(bus.SUM), 'h00);
        chk("b2b_cout2", int'(bus.COUT), 1);
        tick();
        chk("b2b_idle_busy", int'(bus.busy), 0);
        chk("b2b_idle_done", int'(bus.done), 0);
    endtask

    task automatic reset_mid_run();
        int ndone;
        bus.start = 1'b1;
        drive(W'(8'h55), W'(8'h55), 1'b0);
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_pre_busy", int'(bus.busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_sum", int'(bus.SUM), 0);
        chk("rst_cout", int'(bus.COUT), 0);
        ndone = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (bus.done || bus.busy) ndone++;
            tick();
        end
        chk("rst_no_done", ndone, 0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        drive('0, '0, 1'b0);
        tick();
        bus.start = 1'b1;
        tick();
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_sum", int'(bus.SUM), 0);
        chk("reset_cout", int'(bus.COUT), 0);
        bus.start = 1'b0;
        rst       = 1'b0;
        tick();

        run_op("add_35_4a", W'(8'h35), W'(8'h4A), 1'b0, 0);
        run_op("add_ff_01", W'(8'hFF), W'(8'h01), 1'b0, 0);
        run_op("add_ff_ff", W'(8'hFF), W'(8'hFF), 1'b0, 0);
        run_op("ignore", W'(8'h10), W'(8'h20), 1'b0, 3);
        back_to_back();
        reset_mid_run();
        run_op("after_rst", W'(8'h55), W'(8'h55), 1'b0, 0);
`ifdef SERIAL_ADDER_SUB_EN
        run_op("sub_10_01", W'(8'h10), W'(8'h01), 1'b1, 0);
        run_op("sub_01_02", W'(8'h01), W'(8'h02), 1'b1, 0);
`endif
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run_op("rand", ra, rb, rs, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
